// File: rtl/instr_queue_dispatch.sv
// In-order instruction queue with one-hot dispatch to RAM/LS/ARITH units.
// Optional RAM/LOAD_STORE cache fence: define CACHE_FENCE_EN.
module instr_queue_dispatch #(
  parameter int DEPTH   = 8,
  parameter int ADDR_W  = 18,
  parameter int INSTR_W = 16
) (
  input  logic               clk,
  input  logic               reset,
  input  logic               queue_we,
  input  logic [1:0]         queue_instr_type,
  input  logic [INSTR_W-1:0] queue_instr,
  input  logic [ADDR_W-1:0]  cache_addr,
  input  logic [ADDR_W-1:0]  main_mem_addr,
  input  logic               program_complete,
  input  logic [2:0]         unit_busy,
  input  logic [2:0]         disp_ready,
  output logic [2:0]         disp_valid,
  output logic [INSTR_W-1:0] disp_instr,
  output logic [ADDR_W-1:0]  disp_cache_addr,
  output logic [ADDR_W-1:0]  disp_main_mem_addr,
  output logic               queue_full,
  output logic               queue_empty,
  output logic               drain_done,
  output logic [1:0]         err
);

  localparam int PW = $clog2(DEPTH);
  localparam logic [PW:0] FULL_CNT = (PW+1)'(DEPTH);

  localparam logic [1:0] T_RAM   = 2'd0;
  localparam logic [1:0] T_LS    = 2'd1;
  localparam logic [1:0] T_ARITH = 2'd2;
  localparam logic [1:0] T_LOOP  = 2'd3;

  localparam logic [1:0] S_RUN   = 2'd0;
  localparam logic [1:0] S_DRAIN = 2'd1;
  localparam logic [1:0] S_DONE  = 2'd2;

  logic [1:0]         q_type  [DEPTH];
  logic [INSTR_W-1:0] q_instr [DEPTH];
  logic [ADDR_W-1:0]  q_caddr [DEPTH];
  logic [ADDR_W-1:0]  q_maddr [DEPTH];

  logic [PW-1:0] wr_ptr;
  logic [PW-1:0] rd_ptr;
  logic [PW:0]   count;
  logic [1:0]    state;
  logic [1:0]    head_type;
  logic [2:0]    head_sel;
  logic          hold;
  logic          push_ok;
  logic          pop;

  assign queue_full  = (count == FULL_CNT);
  assign queue_empty = (count == '0);
  assign push_ok     = queue_we && !queue_full
                       && (queue_instr_type != T_LOOP);

  assign head_type          = q_type[rd_ptr];
  assign disp_instr         = q_instr[rd_ptr];
  assign disp_cache_addr    = q_caddr[rd_ptr];
  assign disp_main_mem_addr = q_maddr[rd_ptr];

  always_comb begin
    head_sel = 3'b000;
    unique case (1'b1)
      (head_type == T_RAM):   head_sel = 3'b001;
      (head_type == T_LS):    head_sel = 3'b010;
      (head_type == T_ARITH): head_sel = 3'b100;
      default:                head_sel = 3'b000;
    endcase
  end

`ifdef CACHE_FENCE_EN
  // RAM and LOAD_STORE share the cache port; never overlap them.
  assign hold = ((head_type == T_RAM) && unit_busy[1])
             || ((head_type == T_LS)  && unit_busy[0]);
`else
  assign hold = 1'b0;
`endif

  assign disp_valid = (!queue_empty && !hold) ? head_sel : 3'b000;
  assign pop        = |(disp_valid & disp_ready);
  assign drain_done = (state == S_DONE);

  always_ff @(posedge clk) begin
    if (push_ok) begin
      q_type[wr_ptr]  <= queue_instr_type;
      q_instr[wr_ptr] <= queue_instr;
      q_caddr[wr_ptr] <= cache_addr;
      q_maddr[wr_ptr] <= main_mem_addr;
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      wr_ptr <= '0;
      rd_ptr <= '0;
      count  <= '0;
      err    <= 2'b00;
    end else begin
      if (push_ok) wr_ptr <= wr_ptr + 1'b1;
      if (pop)     rd_ptr <= rd_ptr + 1'b1;
      if (push_ok && !pop)      count <= count + 1'b1;
      else if (!push_ok && pop) count <= count - 1'b1;
      err <= err | {queue_we && (queue_instr_type == T_LOOP),
                    queue_we && queue_full};
    end
  end

  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state <= S_RUN;
    end else begin
      unique case (state)
        S_RUN:
          if (program_complete) state <= S_DRAIN;
        S_DRAIN:
          if (!program_complete)
            state <= S_RUN;
          else if (queue_empty && unit_busy == 3'b000 && !push_ok)
            state <= S_DONE;
        S_DONE:
          if (push_ok) state <= S_RUN;
        default:
          state <= S_RUN;
      endcase
    end
  end

endmodule

// File: tb/tb_instr_queue_dispatch.sv
// Scoreboard bench for instr_queue_dispatch: directed pushes, monitor
// compares every dispatch handshake against the expected in-order stream.
module tb_instr_queue_dispatch;

  localparam logic [1:0] T_RAM   = 2'd0;
  localparam logic [1:0] T_LS    = 2'd1;
  localparam logic [1:0] T_ARITH = 2'd2;
  localparam logic [1:0] T_LOOP  = 2'd3;

  typedef struct packed {
    logic [2:0]  v;
    logic [15:0] instr;
    logic [17:0] ca;
    logic [17:0] ma;
  } exp_t;

  logic        clk;
  logic        reset;
  logic        queue_we;
  logic [1:0]  queue_instr_type;
  logic [15:0] queue_instr;
  logic [17:0] cache_addr;
  logic [17:0] main_mem_addr;
  logic        program_complete;
  logic [2:0]  unit_busy;
  logic [2:0]  disp_ready;
  logic [2:0]  disp_valid;
  logic [15:0] disp_instr;
  logic [17:0] disp_cache_addr;
  logic [17:0] disp_main_mem_addr;
  logic        queue_full;
  logic        queue_empty;
  logic        drain_done;
  logic [1:0]  err;

  int   errors = 0;
  int   checks = 0;
  exp_t sb[$];

  instr_queue_dispatch dut (
    .clk(clk), .reset(reset),
    .queue_we(queue_we), .queue_instr_type(queue_instr_type),
    .queue_instr(queue_instr), .cache_addr(cache_addr),
    .main_mem_addr(main_mem_addr), .program_complete(program_complete),
    .unit_busy(unit_busy), .disp_ready(disp_ready),
    .disp_valid(disp_valid), .disp_instr(disp_instr),
    .disp_cache_addr(disp_cache_addr),
    .disp_main_mem_addr(disp_main_mem_addr),
    .queue_full(queue_full), .queue_empty(queue_empty),
    .drain_done(drain_done), .err(err)
  );

  initial begin
    clk = 0;
    forever #5 clk = ~clk;
  end

  task automatic chk(input string name, input logic [63:0] got,
                     input logic [63:0] exp);
    checks++;
    if (got !== exp) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h", name, got, exp);
    end
  endtask

  function automatic logic [2:0] sel(input logic [1:0] t);
    case (t)
      T_RAM:   return 3'b001;
      T_LS:    return 3'b010;
      T_ARITH: return 3'b100;
      default: return 3'b000;
    endcase
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic push(input logic [1:0] t, input logic [15:0] ins,
                      input logic [17:0] ca, input logic [17:0] ma,
                      input bit acc);
    queue_we         = 1'b1;
    queue_instr_type = t;
    queue_instr      = ins;
    cache_addr       = ca;
    main_mem_addr    = ma;
    if (acc) sb.push_back('{sel(t), ins, ca, ma});
    tick();
    queue_we = 1'b0;
  endtask

  // Monitor: each handshake seen mid-cycle fires on the next edge.
  always @(negedge clk) begin
    if (reset && |(disp_valid & disp_ready)) begin
      if (sb.size() == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_dispatch: got valid=%b instr=%0h expected none",
                 disp_valid, disp_instr);
      end else begin
        exp_t e;
        e = sb.pop_front();
        chk("mon_valid", disp_valid, e.v);
        chk("mon_instr", disp_instr, e.instr);
        chk("mon_caddr", disp_cache_addr, e.ca);
        chk("mon_maddr", disp_main_mem_addr, e.ma);
      end
    end
  end

  initial begin
    reset = 0; queue_we = 0; queue_instr_type = 0; queue_instr = 0;
    cache_addr = 0; main_mem_addr = 0; program_complete = 0;
    unit_busy = 0; disp_ready = 0;
    #2;
    chk("rst_valid", disp_valid, 3'b000);
    chk("rst_empty", queue_empty, 1);
    chk("rst_full", queue_full, 0);
    chk("rst_done", drain_done, 0);
    chk("rst_err", err, 2'b00);
    tick();
    reset = 1;
    tick();

    // single RAM push, immediate dispatch
    disp_ready = 3'b111;
    push(T_RAM, 16'h00A1, 18'd0, 18'd3, 1);
    chk("t1_valid", disp_valid, 3'b001);
    chk("t1_caddr", disp_cache_addr, 18'd0);
    chk("t1_maddr", disp_main_mem_addr, 18'd3);
    tick();
    chk("t1_empty", queue_empty, 1);

    // fill, overflow, then drain in order
    disp_ready = 3'b000;
    for (int i = 0; i < 8; i++) push(T_ARITH, 16'(i), 18'(i), 18'(i + 100), 1);
    chk("t2_full", queue_full, 1);
    push(T_ARITH, 16'h0099, 18'd9, 18'd9, 0);
    chk("t2_err", err, 2'b01);
    chk("t2_full_after", queue_full, 1);
    disp_ready = 3'b100;
    for (int i = 0; i < 8; i++) begin
      chk("t2_stream_valid", disp_valid, 3'b100);
      tick();
    end
    chk("t2_empty", queue_empty, 1);
    chk("t2_idle", disp_valid, 3'b000);

    // cache fence
    disp_ready = 3'b111;
    unit_busy  = 3'b001;
    push(T_LS, 16'h0055, 18'd7, 18'd8, 1);
`ifdef CACHE_FENCE_EN
    for (int i = 0; i < 5; i++) begin
      chk("t3_fenced", disp_valid, 3'b000);
      tick();
    end
    unit_busy = 3'b000;
    #1;
    chk("t3_release", disp_valid, 3'b010);
`else
    chk("t3_nofence", disp_valid, 3'b010);
`endif
    tick();
    unit_busy = 3'b000;
    chk("t3_empty", queue_empty, 1);

    // illegal LOOP type
    push(T_LOOP, 16'h0077, 18'd1, 18'd1, 0);
    chk("t4_err", err, 2'b11);
    chk("t4_valid", disp_valid, 3'b000);
    tick();
    chk("t4_empty", queue_empty, 1);

    // mixed stream and drain
    disp_ready = 3'b000;
    push(T_RAM,   16'h0010, 18'd10, 18'd20, 1);
    push(T_LS,    16'h0011, 18'd11, 18'd21, 1);
    push(T_ARITH, 16'h0012, 18'd12, 18'd22, 1);
    push(T_LS,    16'h0013, 18'd13, 18'd23, 1);
    push(T_RAM,   16'h0014, 18'd14, 18'd24, 1);
    program_complete = 1;
    unit_busy  = 3'b100;
    disp_ready = 3'b111;
    for (int i = 0; i < 20 && !queue_empty; i++) tick();
    chk("t5_drained", queue_empty, 1);
    tick();
    chk("t5_busy_nodone", drain_done, 0);
    unit_busy = 3'b000;
    #1;
    chk("t5_not_yet", drain_done, 0);
    tick();
    chk("t5_done", drain_done, 1);
    push(T_ARITH, 16'h0020, 18'd30, 18'd40, 1);
    chk("t5_done_clr", drain_done, 0);
    program_complete = 0;
    tick();
    tick();

    // async reset mid-cycle with entries queued
    disp_ready = 3'b000;
    push(T_RAM,   16'h0030, 18'd1, 18'd2, 0);
    push(T_ARITH, 16'h0031, 18'd3, 18'd4, 0);
    push(T_LS,    16'h0032, 18'd5, 18'd6, 0);
    #2;
    reset = 0;
    #1;
    chk("t6_valid", disp_valid, 3'b000);
    chk("t6_empty", queue_empty, 1);
    chk("t6_err", err, 2'b00);
    tick();
    reset = 1;
    tick();
    tick();

    chk("sb_drained", sb.size(), 0);
    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule
